// File: rtl/sfr_timer_pkg.sv
// Shared constants for the SFR timer bank: register map, CTRL bit indices, byte-lane merge.
// CAPTURE_EN (optional define) enables the per-channel input-capture path.
package sfr_timer_pkg;

  localparam logic [7:0] ADDR_PEND  = 8'h00;
  localparam logic [7:0] ADDR_MASK  = 8'h02;
  localparam logic [7:0] ADDR_PRESC = 8'h04;
  localparam logic [7:0] ADDR_INFO  = 8'h06;
  localparam logic [7:0] CH_BASE    = 8'h10;
  localparam logic [7:0] CH_STRIDE  = 8'h08;

  localparam logic [2:0] CH_CTRL = 3'h0;
  localparam logic [2:0] CH_CMP  = 3'h2;
  localparam logic [2:0] CH_CNT  = 3'h4;
  localparam logic [2:0] CH_CAP  = 3'h6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CAPFALL = 2;

  localparam logic [3:0] INFO_VER = 4'h1;

`ifdef CAPTURE_EN
  localparam bit CAP_ON = 1'b1;
`else
  localparam bit CAP_ON = 1'b0;
`endif

  // Apply a 16-bit write to a 16-bit register image, honouring byte enables.
  function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] wd,
                                         input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

endpackage

// File: rtl/sfr_timer_chan.sv
// One compare timer channel: CTRL/CMP/CNT/CAP registers, match and capture event pulses.
// With CAPTURE_EN defined, cap_in is synchronised and edge-detected to capture CNT.
module sfr_timer_chan
  import sfr_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       wr_ctrl,
  input  logic [1:0]       wr_cmp,
  input  logic [1:0]       wr_cnt,
  input  logic [15:0]      wdata,
  input  logic             cap_in,
  output logic [2:0]       ctrl,
  output logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cap,
  output logic             match,
  output logic             capt
);

  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] cmp_q, cmp_d, cnt_q, cnt_d, cap_q, cap_d;

`ifdef CAPTURE_EN
  // [0],[1] synchroniser, [2] previous value for edge detection
  logic [2:0] sync_q, sync_d;
  assign sync_d = {sync_q[1:0], cap_in};
  assign capt   = ctrl_q[CTRL_CAPFALL] ? (sync_q[2] & ~sync_q[1]) : (sync_q[1] & ~sync_q[2]);

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign capt = 1'b0;
`endif

  always_comb begin
    ctrl_d = ctrl_q;
    cmp_d  = cmp_q;
    cnt_d  = cnt_q;
    match  = 1'b0;
    // A CPU write to CTRL or CNT swallows a coincident tick.
    if (tick && ctrl_q[CTRL_EN] && wr_ctrl == 2'b00 && wr_cnt == 2'b00) begin
      if (cnt_q == cmp_q) begin
        cnt_d = '0;
        match = 1'b1;
        if (ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    if (|wr_ctrl) begin
      ctrl_d = 3'(bmerge(16'(ctrl_q), wdata, wr_ctrl));
      if (!CAP_ON) ctrl_d[CTRL_CAPFALL] = 1'b0;
    end
    if (|wr_cmp) cmp_d = WIDTH'(bmerge(16'(cmp_q), wdata, wr_cmp));
    if (|wr_cnt) cnt_d = WIDTH'(bmerge(16'(cnt_q), wdata, wr_cnt));
    cap_d = capt ? cnt_q : cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      cmp_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      cmp_q  <= cmp_d;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
    end
  end

  assign ctrl = ctrl_q;
  assign cmp  = cmp_q;
  assign cnt  = cnt_q;
  assign cap  = cap_q;

endmodule

// File: rtl/sfr_timer_bank.sv
// NCH-channel compare timer bank on the b16 SFR bus: prescaler, W1C pending, mask, registered irq.
// CAPTURE_EN (optional define) adds capture pending/mask bits [15:8] and CAP registers.
module sfr_timer_bank
  import sfr_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int PSW   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           drun,
  input  logic           sel,
  input  logic [7:0]     addr,
  input  logic           r,
  input  logic [1:0]     w,
  input  logic [15:0]    dwrite,
  output logic [15:0]    sfr_data,
  input  logic [NCH-1:0] cap_in,
  output logic           irq
);

  logic [7:0] addr_e, off;
  logic [2:0] ch_idx;
  logic       in_ch, wr_any;
  logic       unused_addr0;

  assign unused_addr0 = addr[0];
  assign addr_e = {addr[7:1], 1'b0};
  assign off    = addr_e - CH_BASE;
  assign ch_idx = off[5:3];
  assign in_ch  = (addr_e >= CH_BASE) && (off[7:3] < 5'(NCH));
  assign wr_any = sel && (|w);

  logic [NCH-1:0][1:0]       wr_ctrl, wr_cmp, wr_cnt;
  logic [NCH-1:0][2:0]       ch_ctrl;
  logic [NCH-1:0][WIDTH-1:0] ch_cmp, ch_cnt, ch_cap;
  logic [NCH-1:0]            ch_match, ch_capt;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ctrl[c] = (sel && in_ch && ch_idx == 3'(c) && off[2:0] == CH_CTRL) ? w : 2'b00;
      wr_cmp[c]  = (sel && in_ch && ch_idx == 3'(c) && off[2:0] == CH_CMP)  ? w : 2'b00;
      wr_cnt[c]  = (sel && in_ch && ch_idx == 3'(c) && off[2:0] == CH_CNT)  ? w : 2'b00;
    end
  end

  logic       tick;
  logic [PSW-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [NCH-1:0] pend_cmp_q, pend_cmp_d, pend_cap_q, pend_cap_d;
  logic [NCH-1:0] mask_cmp_q, mask_cmp_d, mask_cap_q, mask_cap_d;
  logic           irq_q, irq_d;
  logic           wr_pend, wr_mask, wr_presc;

  assign wr_pend  = wr_any && addr_e == ADDR_PEND;
  assign wr_mask  = wr_any && addr_e == ADDR_MASK;
  assign wr_presc = wr_any && addr_e == ADDR_PRESC;
  assign tick     = drun && (pcnt_q == presc_q);

  always_comb begin
    presc_d = wr_presc ? PSW'(bmerge(16'(presc_q), dwrite, w)) : presc_q;
    pcnt_d  = pcnt_q;
    if (drun) pcnt_d = tick ? '0 : pcnt_q + PSW'(1);
    if (wr_presc) pcnt_d = '0;

    // Clear first, then OR in hardware events so a coincident set survives.
    pend_cmp_d = pend_cmp_q;
    pend_cap_d = pend_cap_q;
    if (wr_pend && w[0]) pend_cmp_d = pend_cmp_d & ~dwrite[NCH-1:0];
    if (wr_pend && w[1]) pend_cap_d = pend_cap_d & ~dwrite[8 +: NCH];
    pend_cmp_d = pend_cmp_d | ch_match;
    pend_cap_d = pend_cap_d | ch_capt;

    mask_cmp_d = mask_cmp_q;
    mask_cap_d = mask_cap_q;
    if (wr_mask && w[0])           mask_cmp_d = dwrite[NCH-1:0];
    if (CAP_ON && wr_mask && w[1]) mask_cap_d = dwrite[8 +: NCH];

    irq_d = |((pend_cmp_q & mask_cmp_q) | (pend_cap_q & mask_cap_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      pcnt_q     <= '0;
      pend_cmp_q <= '0;
      pend_cap_q <= '0;
      mask_cmp_q <= '0;
      mask_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      pend_cmp_q <= pend_cmp_d;
      pend_cap_q <= pend_cap_d;
      mask_cmp_q <= mask_cmp_d;
      mask_cap_q <= mask_cap_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sfr_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr_ctrl (wr_ctrl[c]),
      .wr_cmp  (wr_cmp[c]),
      .wr_cnt  (wr_cnt[c]),
      .wdata   (dwrite),
      .cap_in  (cap_in[c]),
      .ctrl    (ch_ctrl[c]),
      .cmp     (ch_cmp[c]),
      .cnt     (ch_cnt[c]),
      .cap     (ch_cap[c]),
      .match   (ch_match[c]),
      .capt    (ch_capt[c])
    );
  end

  always_comb begin
    sfr_data = '0;
    if (r && sel) begin
      case (addr_e)
        ADDR_PEND:  sfr_data = {8'(pend_cap_q), 8'(pend_cmp_q)};
        ADDR_MASK:  sfr_data = {8'(mask_cap_q), 8'(mask_cmp_q)};
        ADDR_PRESC: sfr_data = 16'(presc_q);
        ADDR_INFO:  sfr_data = {INFO_VER, 4'(NCH), 8'(WIDTH)};
        default: begin
          for (int c = 0; c < NCH; c++) begin
            if (in_ch && ch_idx == 3'(c)) begin
              case (off[2:0])
                CH_CTRL: sfr_data = 16'(ch_ctrl[c]);
                CH_CMP:  sfr_data = 16'(ch_cmp[c]);
                CH_CNT:  sfr_data = 16'(ch_cnt[c]);
                CH_CAP:  sfr_data = 16'(ch_cap[c]);
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfr_timer_bank.sv
// Directed bench for sfr_timer_bank at default parameters (NCH=4, WIDTH=16, PSW=8).
// Define CAPTURE_EN for both bench and RTL to exercise the capture path.
module tb_sfr_timer_bank;

  logic        clk, reset, drun, sel, r, irq;
  logic [7:0]  addr;
  logic [1:0]  w;
  logic [15:0] dwrite, sfr_data;
  logic [3:0]  cap_in;

  int n_chk  = 0;
  int n_fail = 0;

  sfr_timer_bank dut (
    .clk(clk), .reset(reset), .drun(drun), .sel(sel), .addr(addr), .r(r), .w(w),
    .dwrite(dwrite), .sfr_data(sfr_data), .cap_in(cap_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] A_PEND = 8'h00, A_MASK = 8'h02, A_PRESC = 8'h04, A_INFO = 8'h06;

  function automatic logic [7:0] cha(input int c, input int o);
    return 8'(16 + 8 * c + o);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    sel = 1'b1; addr = a; dwrite = d; w = be;
    @(posedge clk);
    #1;
    sel = 1'b0; w = 2'b00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] v);
    sel = 1'b1; r = 1'b1; addr = a;
    #1;
    v = sfr_data;
    sel = 1'b0; r = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1; drun = 1'b0; sel = 1'b0; r = 1'b0; w = 2'b00;
    addr = '0; dwrite = '0; cap_in = '0;
    step(2);
    reset = 1'b0;
    rchk("rst_pend", A_PEND, 16'h0000);
    rchk("rst_mask", A_MASK, 16'h0000);
    rchk("rst_ctrl0", cha(0, 0), 16'h0000);
    rchk("rst_cnt0", cha(0, 4), 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    rchk("info", A_INFO, 16'h1410);

    // Periodic compare, PRESCALE=0: CTRL write at edge C, matches at C+4, C+8, ...
    drun = 1'b1;
    wr(A_MASK, 16'h0001, 2'b11);
    wr(cha(0, 2), 16'd3, 2'b11);
    wr(cha(0, 0), 16'd1, 2'b11);
    rchk("t1_cnt_c0", cha(0, 4), 16'd0);
    step(3);
    rchk("t1_cnt_c3", cha(0, 4), 16'd3);
    rchk("t1_pend_c3", A_PEND, 16'h0000);
    step(1);
    rchk("t1_pend_c4", A_PEND, 16'h0001);
    chk("t1_irq_c4", 16'(irq), 16'h0000);
    rchk("t1_cnt_c4", cha(0, 4), 16'd0);
    step(1);
    chk("t1_irq_c5", 16'(irq), 16'h0001);
    wr(A_PEND, 16'h0001, 2'b01);
    rchk("t1_w1c_c6", A_PEND, 16'h0000);
    chk("t1_irq_c6", 16'(irq), 16'h0001);
    step(1);
    chk("t1_irq_c7", 16'(irq), 16'h0000);
    // W1C lands on the match edge C+8: the set must win.
    wr(A_PEND, 16'h0001, 2'b01);
    rchk("t4_setwins", A_PEND, 16'h0001);
    step(1);
    chk("t4_irq_c9", 16'(irq), 16'h0001);
    wr(A_PEND, 16'h0001, 2'b01);
    rchk("t4_w1c_c10", A_PEND, 16'h0000);
    step(1);
    chk("t4_irq_c11", 16'(irq), 16'h0000);
    // CTRL write on the C+12 match tick drops the tick.
    wr(cha(0, 0), 16'd0, 2'b11);
    rchk("t1_wrwins_cnt", cha(0, 4), 16'd3);
    rchk("t1_wrwins_pend", A_PEND, 16'h0000);

    // One-shot, PRESCALE=2 written at edge D; ticks at D+3, D+6.
    wr(A_PRESC, 16'd2, 2'b11);
    wr(cha(1, 2), 16'd1, 2'b11);
    wr(cha(1, 0), 16'd3, 2'b11);
    step(3);
    rchk("t2_cnt_d5", cha(1, 4), 16'd1);
    rchk("t2_pend_d5", A_PEND, 16'h0000);
    step(1);
    rchk("t2_pend_d6", A_PEND, 16'h0002);
    rchk("t2_ctrl_d6", cha(1, 0), 16'h0002);  // EN cleared, ONESHOT kept
    step(6);
    rchk("t2_cnt_hold", cha(1, 4), 16'd0);
    rchk("t2_pend_hold", A_PEND, 16'h0002);
    chk("t2_irq_masked", 16'(irq), 16'h0000);

    // drun freeze: ticks at D+18, D+21; then 10 frozen cycles.
    wr(A_PEND, 16'h0002, 2'b01);
    wr(cha(2, 2), 16'd100, 2'b11);
    wr(cha(2, 0), 16'd1, 2'b11);
    step(6);
    rchk("t3_cnt_run", cha(2, 4), 16'd2);
    drun = 1'b0;
    step(10);
    rchk("t3_cnt_frozen", cha(2, 4), 16'd2);
    drun = 1'b1;
    step(2);
    rchk("t3_cnt_resume2", cha(2, 4), 16'd2);
    step(1);
    rchk("t3_cnt_resume3", cha(2, 4), 16'd3);

    // Byte lanes and decode.
    wr(cha(3, 2), 16'h1234, 2'b11);
    wr(cha(3, 2), 16'hAB00, 2'b10);
    rchk("t5_cmp_hibyte", cha(3, 2), 16'hAB34);
    wr(cha(4, 0), 16'hFFFF, 2'b11);
    rchk("t5_ch4_ctrl", cha(4, 0), 16'h0000);
    rchk("t5_unmapped", 8'h08, 16'h0000);
    rchk("t5_info_odd", 8'h07, 16'h1410);
    sel = 1'b1; r = 1'b0; addr = A_INFO; #1;
    chk("t5_no_rd", sfr_data, 16'h0000);
    sel = 1'b0;
    wr(A_PRESC, 16'h1234, 2'b11);
    rchk("t5_presc", A_PRESC, 16'h0034);
    wr(A_MASK, 16'hFF01, 2'b11);
    wr(cha(3, 0), 16'h0006, 2'b11);
`ifdef CAPTURE_EN
    rchk("t5_mask_hi", A_MASK, 16'h0F01);
    rchk("t5_ctrl_bits", cha(3, 0), 16'h0006);
`else
    rchk("t5_mask_hi", A_MASK, 16'h0001);
    rchk("t5_ctrl_bits", cha(3, 0), 16'h0002);
`endif

    // Counter wrap without event, and CNT write beating a tick.
    wr(A_PRESC, 16'd0, 2'b11);
    wr(cha(3, 4), 16'hFFFF, 2'b11);
    wr(cha(3, 0), 16'h0001, 2'b11);
    rchk("wrap_pre", cha(3, 4), 16'hFFFF);
    step(1);
    rchk("wrap_cnt", cha(3, 4), 16'h0000);
    rd(A_PEND, v);
    chk("wrap_nopend", v & 16'h0008, 16'h0000);
    wr(cha(3, 4), 16'h0010, 2'b11);
    rchk("cnt_wr_wins", cha(3, 4), 16'h0010);

    // Capture on CH2 with the channel stopped.
    wr(cha(2, 0), 16'h0000, 2'b11);
    wr(cha(2, 4), 16'h0042, 2'b11);
    wr(A_PEND, 16'h00FF, 2'b01);
    cap_in[2] = 1'b1;
    step(2);
    rd(A_PEND, v);
    chk("t6_pend_early", v & 16'h0400, 16'h0000);
    step(1);
    rd(A_PEND, v);
`ifdef CAPTURE_EN
    chk("t6_pend_cap", v & 16'h0400, 16'h0400);
    rchk("t6_cap2", cha(2, 6), 16'h0042);
`else
    chk("t6_pend_cap", v & 16'hFF00, 16'h0000);
    rchk("t6_cap2", cha(2, 6), 16'h0000);
`endif

    // Reset in the middle of counting.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rchk("rst2_cnt3", cha(3, 4), 16'h0000);
    rchk("rst2_ctrl3", cha(3, 0), 16'h0000);
    rchk("rst2_cnt2", cha(2, 4), 16'h0000);
    rchk("rst2_presc", A_PRESC, 16'h0000);
    rchk("rst2_mask", A_MASK, 16'h0000);
    rchk("rst2_pend", A_PEND, 16'h0000);
    chk("rst2_irq", 16'(irq), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
